// File: rtl/mask_pkg.sv
// Shared constants and FIFO entry layout for the mask stream writer.
// The entry packs the SRAM word address, the mask bits and an end-of-frame marker.
package mask_pkg;

   localparam int unsigned H_PIXELS      = 640;
   localparam int unsigned V_LINES       = 480;
   localparam int unsigned WORD_W        = 16;
   localparam int unsigned WORDS_PER_ROW = H_PIXELS / WORD_W;
   localparam int unsigned ADDR_W        = 15;
   localparam int unsigned FIFO_DEPTH    = 4;
   localparam int unsigned IDLE_FLUSH    = 32;
   localparam int unsigned IDLE_W        = $clog2(IDLE_FLUSH) + 1;

   typedef enum logic [1:0] {
      PK_EMPTY,
      PK_PARTIAL,
      PK_COMPLETE
   } pack_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [WORD_W-1:0] data;
      logic              last;
   } mask_entry_t;

   localparam int unsigned ENTRY_W = $bits(mask_entry_t);

endpackage

// File: rtl/mask_word_fifo.sv
// Small synchronous FIFO; a push while full is accepted only if a pop frees a slot
// in the same cycle. Storage is cleared on reset so the head reads zero when idle.
module mask_word_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/mask_sram_writer.sv
// Packs the per-pixel mask stream into 16-bit row-aligned words and writes them
// to the mask frame store through a small FIFO and a req/ack SRAM write port.
module mask_sram_writer
   import mask_pkg::*;
(
   input  logic              clk_25,
   input  logic              rst,
   input  logic              valid,
   input  logic              mask,
   input  logic [9:0]        mask_x,
   input  logic [9:0]        mask_y,
   output logic              wr_req,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [WORD_W-1:0] wr_data,
   input  logic              wr_ack,
   output logic              overflow,
   output logic              frame_done
);

   localparam logic [9:0] X_LIM   = 10'(H_PIXELS);
   localparam logic [9:0] Y_LIM   = 10'(V_LINES);
   localparam logic [9:0] Y_LAST  = 10'(V_LINES - 1);
   localparam logic [5:0] WX_LAST = 6'(WORDS_PER_ROW - 1);

   pack_state_t       state, state_nx;
   logic [9:0]        cur_y, cur_y_nx;
   logic [5:0]        cur_wx, cur_wx_nx;
   logic [WORD_W-1:0] data, data_nx;
   logic [IDLE_W-1:0] idle_cnt, idle_nx;

   logic              in_range;
   logic              same_word;
   logic              push;
   logic              pop;
   logic              full;
   logic              empty;
   mask_entry_t       push_entry;
   mask_entry_t       head_entry;
   logic [ENTRY_W-1:0] head_raw;

   assign in_range  = valid && (mask_x < X_LIM) && (mask_y < Y_LIM);
   assign same_word = (mask_y == cur_y) && (mask_x[9:4] == cur_wx);

   // Every push carries the word currently held in the pack register.
   assign push_entry.addr = ADDR_W'({cur_y, 5'b0}) + ADDR_W'({cur_y, 3'b0}) + ADDR_W'(cur_wx);
   assign push_entry.data = data;
   assign push_entry.last = (cur_y == Y_LAST) && (cur_wx == WX_LAST);

   always_ff @(posedge clk_25) begin
      if (rst) begin
         state    <= PK_EMPTY;
         cur_y    <= '0;
         cur_wx   <= '0;
         data     <= '1;
         idle_cnt <= '0;
      end else begin
         state    <= state_nx;
         cur_y    <= cur_y_nx;
         cur_wx   <= cur_wx_nx;
         data     <= data_nx;
         idle_cnt <= idle_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      cur_y_nx  = cur_y;
      cur_wx_nx = cur_wx;
      data_nx   = data;
      idle_nx   = idle_cnt;
      push      = 1'b0;

      if (state == PK_COMPLETE) push = 1'b1;

      if (in_range) begin
         idle_nx = '0;
         if (state == PK_PARTIAL && same_word) begin
            data_nx[mask_x[3:0]] = mask;
         end else begin
            // A new word from PARTIAL flushes the old one with unwritten bits at 1.
            if (state == PK_PARTIAL) push = 1'b1;
            cur_y_nx             = mask_y;
            cur_wx_nx            = mask_x[9:4];
            data_nx              = '1;
            data_nx[mask_x[3:0]] = mask;
         end
         state_nx = (mask_x[3:0] == 4'hF) ? PK_COMPLETE : PK_PARTIAL;
      end else if (state == PK_COMPLETE) begin
         state_nx = PK_EMPTY;
      end else if (state == PK_PARTIAL) begin
         if (idle_cnt == IDLE_W'(IDLE_FLUSH - 1)) begin
            push     = 1'b1;
            state_nx = PK_EMPTY;
            idle_nx  = '0;
         end else begin
            idle_nx = idle_cnt + IDLE_W'(1);
         end
      end
   end

   mask_word_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk       (clk_25),
      .rst       (rst),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head_raw),
      .full      (full),
      .empty     (empty)
   );

   assign head_entry = head_raw;
   assign wr_req     = !empty;
   assign wr_addr    = head_entry.addr;
   assign wr_data    = head_entry.data;
   assign pop        = wr_req && wr_ack;

   // Overflow is sticky until the first pixel of a new frame arrives.
   always_ff @(posedge clk_25) begin
      if (rst) begin
         overflow   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= pop && head_entry.last;
         if (push && full && !pop)
            overflow <= 1'b1;
         else if (in_range && mask_x == '0 && mask_y == '0)
            overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mask_sram_writer.sv
// Scoreboard bench for mask_sram_writer: directed pixel streams push expected
// SRAM writes into a queue that an independent write-port monitor drains.
module tb_mask_sram_writer;
   import mask_pkg::*;

   logic              clk_25 = 1'b0;
   logic              rst;
   logic              valid;
   logic              mask;
   logic [9:0]        mask_x;
   logic [9:0]        mask_y;
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [WORD_W-1:0] wr_data;
   logic              wr_ack;
   logic              overflow;
   logic              frame_done;

   int n_checks = 0;
   int n_pass   = 0;
   int fd_seen  = 0;
   bit fd_pending = 1'b0;
   mask_entry_t exp_q[$];

   mask_sram_writer dut (
      .clk_25     (clk_25),
      .rst        (rst),
      .valid      (valid),
      .mask       (mask),
      .mask_x     (mask_x),
      .mask_y     (mask_y),
      .wr_req     (wr_req),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_ack     (wr_ack),
      .overflow   (overflow),
      .frame_done (frame_done)
   );

   always #5 clk_25 = ~clk_25;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
   endtask

   task automatic expect_write(input int addr, input logic [15:0] d, input logic last);
      mask_entry_t e;
      e.addr = ADDR_W'(addr);
      e.data = d;
      e.last = last;
      exp_q.push_back(e);
   endtask

   // Presents one sample for one clock, then drops valid.
   task automatic sample(input int x, input int y, input logic m);
      valid  = 1'b1;
      mask_x = 10'(x);
      mask_y = 10'(y);
      mask   = m;
      @(posedge clk_25); #1;
      valid  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk_25);
      #1;
   endtask

   task automatic word(input int x0, input int y, input logic [15:0] pat);
      for (int i = 0; i < 16; i++) sample(x0 + i, y, pat[i]);
   endtask

   // Write-port monitor: every accepted write is matched against the scoreboard.
   always @(negedge clk_25) begin
      if (!rst) begin
         if (frame_done) fd_seen++;
         if (fd_pending) begin
            chk("frame_done_pulse", 32'(frame_done), 32'd1);
            fd_pending = 1'b0;
         end else if (frame_done) begin
            chk("frame_done_spurious", 32'(frame_done), 32'd0);
         end
         if (wr_req && wr_ack) begin
            if (exp_q.size() == 0) begin
               chk("write_expected", 32'(exp_q.size()), 32'd1);
            end else begin
               mask_entry_t e;
               e = exp_q.pop_front();
               chk("wr_addr", 32'(wr_addr), 32'(e.addr));
               chk("wr_data", 32'(wr_data), 32'(e.data));
               if (e.last) fd_pending = 1'b1;
            end
         end
      end
   end

   initial begin
      rst    = 1'b1;
      valid  = 1'b0;
      mask   = 1'b0;
      mask_x = '0;
      mask_y = '0;
      wr_ack = 1'b0;
      @(posedge clk_25); @(posedge clk_25);
      @(negedge clk_25);
      chk("rst_wr_req", 32'(wr_req), 32'd0);
      chk("rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      @(posedge clk_25); #1;
      rst = 1'b0;

      // Row start: one full word, wr_req rises two cycles after x=15.
      wr_ack = 1'b1;
      expect_write(0, 16'hA5A5, 1'b0);
      word(0, 0, 16'hA5A5);
      @(negedge clk_25);
      chk("latency_not_yet", 32'(wr_req), 32'd0);
      @(negedge clk_25);
      chk("latency_rise", 32'(wr_req), 32'd1);
      idle(5);

      // Discontinuity flush, then the new word at wx=2 completes.
      expect_write(80, 16'hFFF0, 1'b0);
      expect_write(82, 16'hFFFE, 1'b0);
      for (int i = 0; i < 4; i++) sample(i, 2, 1'b0);
      word(32, 2, 16'hFFFE);
      idle(5);

      // Idle flush after exactly IDLE_FLUSH idle cycles.
      expect_write(40, 16'hFFE0, 1'b0);
      for (int i = 0; i < 5; i++) sample(i, 1, 1'b0);
      idle(31);
      @(negedge clk_25);
      chk("idle_not_yet", 32'(wr_req), 32'd0);
      @(negedge clk_25);
      chk("idle_flush_req", 32'(wr_req), 32'd1);
      idle(5);

      // Backpressure: five words, four retained, fifth dropped.
      wr_ack = 1'b0;
      for (int k = 0; k < 4; k++) expect_write(120 + k, 16'h1111 * 16'(k + 1), 1'b0);
      for (int k = 0; k < 5; k++) word(16 * k, 3, 16'h1111 * 16'(k + 1));
      idle(2);
      @(negedge clk_25);
      chk("overflow_set", 32'(overflow), 32'd1);
      chk("bp_req_held", 32'(wr_req), 32'd1);
      chk("bp_head_stable", 32'(wr_addr), 32'd120);
      idle(1);
      sample(0, 0, 1'b1);
      @(negedge clk_25);
      chk("overflow_cleared", 32'(overflow), 32'd0);
      expect_write(0, 16'hFFFF, 1'b0);
      idle(1);
      wr_ack = 1'b1;
      idle(45);

      // Frame end: last word of the frame, frame_done after its ack.
      expect_write(19199, 16'h0000, 1'b1);
      word(624, 479, 16'h0000);
      idle(10);
      chk("frame_done_count", 32'(fd_seen), 32'd1);

      // Out-of-range samples produce nothing.
      sample(640, 0, 1'b0);
      sample(5, 480, 1'b0);
      idle(40);

      // Reset mid-word discards the partial word.
      for (int i = 0; i < 8; i++) sample(i, 0, 1'b0);
      rst = 1'b1;
      @(posedge clk_25); #1;
      rst = 1'b0;
      @(negedge clk_25);
      chk("mid_rst_wr_req", 32'(wr_req), 32'd0);
      chk("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("mid_rst_wr_data", 32'(wr_data), 32'd0);
      chk("mid_rst_overflow", 32'(overflow), 32'd0);
      idle(40);
      expect_write(200, 16'h3C0F, 1'b0);
      word(0, 5, 16'h3C0F);
      idle(10);

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      chk("frame_done_total", 32'(fd_seen), 32'd1);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
